reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 95 +++++++++
 tb/tb_reg_scoreboard.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters gate issue on RAW/full hazards.
// stall/issue_fire are combinational from the current state; counters update one edge after issue or write-back.
module reg_scoreboard #(
  parameter int RF_NUM = 32,
  parameter int CNT_W  = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rj,
  input  logic [4:0]        issue_rk,
  input  logic [4:0]        issue_rd,
  input  logic              use_rj,
  input  logic              use_rk,
  input  logic              use_rd,
  input  logic              issue_we,
  input  logic [4:0]        issue_wr,
  input  logic              wb_valid,
  input  logic [4:0]        wb_rd,
  input  logic              flush,
  output logic              stall,
  output logic              issue_fire,
  output logic [RF_NUM-1:0] busy,
  output logic [6:0]        inflight,
  output logic              wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [RF_NUM];
  logic [CNT_W-1:0] cnt_d [RF_NUM];
  logic [6:0]       inflight_q, inflight_d;
  logic             wb_err_q, wb_err_d;

  logic haz_rj, haz_rk, haz_rd, full_wr;
  logic inc_en, wb_en, pair, dec_en;

  // A count of exactly one being retired this cycle is bypassed by regfile write-through.
  function automatic logic src_haz(input logic use_b, input logic [4:0] idx,
                                   input logic [CNT_W-1:0] c, input logic wbv,
                                   input logic [4:0] wbi);
    src_haz = use_b && (idx != 5'd0) && (c != '0) &&
              !((c == CNT_ONE) && wbv && (wbi == idx));
  endfunction

  always_comb begin
    haz_rj     = src_haz(use_rj, issue_rj, cnt_q[issue_rj], wb_valid, wb_rd);
    haz_rk     = src_haz(use_rk, issue_rk, cnt_q[issue_rk], wb_valid, wb_rd);
    haz_rd     = src_haz(use_rd, issue_rd, cnt_q[issue_rd], wb_valid, wb_rd);
    full_wr    = issue_we && (issue_wr != 5'd0) && (cnt_q[issue_wr] == CNT_MAX);
    stall      = aresetn && issue_valid && (haz_rj || haz_rk || haz_rd || full_wr);
    issue_fire = aresetn && issue_valid && !stall && !flush;
  end

  always_comb begin
    inc_en   = issue_fire && issue_we && (issue_wr != 5'd0);
    wb_en    = wb_valid && (wb_rd != 5'd0);
    // Issue and write-back to the same register cancel, even from an empty counter.
    pair     = inc_en && wb_en && (wb_rd == issue_wr);
    dec_en   = wb_en && !pair && (cnt_q[wb_rd] != '0);
    wb_err_d = wb_err_q || (wb_en && !pair && !flush && (cnt_q[wb_rd] == '0));
    for (int i = 0; i < RF_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush || i == 0) begin
        cnt_d[i] = '0;
      end else if (!pair) begin
        if (inc_en && (issue_wr == 5'(i))) cnt_d[i] = cnt_q[i] + CNT_ONE;
        if (dec_en && (wb_rd == 5'(i)))    cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    if (flush) inflight_d = '0;
    else       inflight_d = inflight_q + {6'd0, inc_en && !pair} - {6'd0, dec_en};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < RF_NUM; i++) cnt_q[i] <= '0;
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < RF_NUM; i++) cnt_q[i] <= cnt_d[i];
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < RF_NUM; i++) busy[i] = (cnt_q[i] != '0);
  end

  assign inflight = inflight_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: per-cycle reference model compare plus hand-computed spot checks.
module tb_reg_scoreboard;
  localparam int N    = 32;
  localparam int MAXC = 3;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        issue_valid, use_rj, use_rk, use_rd, issue_we, wb_valid, flush;
  logic [4:0]  issue_rj, issue_rk, issue_rd, issue_wr, wb_rd;
  logic        stall, issue_fire, wb_err;
  logic [N-1:0] busy;
  logic [6:0]  inflight;

  int errors = 0;
  int checks = 0;

  int m_cnt [N];
  bit m_err;

  reg_scoreboard #(.RF_NUM(N), .CNT_W(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .issue_valid(issue_valid),
    .issue_rj(issue_rj), .issue_rk(issue_rk), .issue_rd(issue_rd),
    .use_rj(use_rj), .use_rk(use_rk), .use_rd(use_rd),
    .issue_we(issue_we), .issue_wr(issue_wr), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .stall(stall), .issue_fire(issue_fire), .busy(busy),
    .inflight(inflight), .wb_err(wb_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_haz(input bit u, input logic [4:0] idx);
    if (!u || idx == 0 || m_cnt[idx] == 0) return 0;
    return !(m_cnt[idx] == 1 && wb_valid && wb_rd == idx);
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_haz(use_rj, issue_rj) || m_haz(use_rk, issue_rk) ||
           m_haz(use_rd, issue_rd) || (issue_we && issue_wr != 0 && m_cnt[issue_wr] == MAXC));
  endfunction

  function automatic logic [N-1:0] m_busy();
    logic [N-1:0] b = '0;
    for (int i = 1; i < N; i++) b[i] = (m_cnt[i] > 0);
    return b;
  endfunction

  function automatic int m_sum();
    int s = 0;
    for (int i = 0; i < N; i++) s += m_cnt[i];
    return s;
  endfunction

  always @(negedge aclk) begin : cmp
    bit st, fi;
    int inc_idx;
    if (!aresetn) begin
      chk("rst_stall", stall, 0);
      chk("rst_fire", issue_fire, 0);
      chk("rst_busy", busy, 0);
      chk("rst_inflight", inflight, 0);
      chk("rst_wb_err", wb_err, 0);
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_err = 0;
    end else begin
      st = m_stall();
      fi = issue_valid && !st && !flush;
      chk("stall", stall, st);
      chk("issue_fire", issue_fire, fi);
      chk("busy", busy, m_busy());
      chk("inflight", inflight, m_sum());
      chk("wb_err", wb_err, m_err);
      if (flush) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
        inc_idx = (fi && issue_we && issue_wr != 0) ? int'(issue_wr) : 0;
        if (wb_valid && wb_rd != 0) begin
          if (int'(wb_rd) == inc_idx) inc_idx = 0;
          else if (m_cnt[wb_rd] > 0) m_cnt[wb_rd]--;
          else m_err = 1;
        end
        if (inc_idx != 0) m_cnt[inc_idx]++;
      end
    end
  end

  task automatic idle();
    issue_valid = 0; use_rj = 0; use_rk = 0; use_rd = 0;
    issue_rj = 0; issue_rk = 0; issue_rd = 0;
    issue_we = 0; issue_wr = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr(input logic [4:0] r);
    idle();
    issue_valid = 1; issue_we = 1; issue_wr = r;
  endtask

  task automatic wb(input logic [4:0] r);
    idle();
    wb_valid = 1; wb_rd = r;
  endtask

  initial begin
    logic [4:0] five_regs [5];
    five_regs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};
    idle();
    issue_valid = 1; issue_we = 1; issue_wr = 5;
    #2;
    chk("lit_rst_stall", stall, 0);
    chk("lit_rst_fire", issue_fire, 0);
    chk("lit_rst_busy", busy, 0);
    repeat (2) tick();
    aresetn = 1;
    idle();

    // Read-after-write with write-through bypass
    wr(5); #1;
    chk("lit_r5_fire", issue_fire, 1);
    tick(); idle();
    issue_valid = 1; use_rj = 1; issue_rj = 5; #1;
    chk("lit_r5_stall", stall, 1);
    chk("lit_r5_busy", busy[5], 1);
    chk("lit_r5_inflight", inflight, 1);
    wb_valid = 1; wb_rd = 5; #1;
    chk("lit_r5_bypass_stall", stall, 0);
    chk("lit_r5_bypass_fire", issue_fire, 1);
    tick(); idle(); #1;
    chk("lit_r5_drained", inflight, 0);

    // Saturation on r7
    for (int i = 0; i < 3; i++) begin wr(7); tick(); end
    wr(7); #1;
    chk("lit_r7_full_stall", stall, 1);
    chk("lit_r7_inflight3", inflight, 3);
    tick();
    wb_valid = 1; wb_rd = 7; #1;
    chk("lit_r7_full_wb_stall", stall, 1);
    tick();
    wb_valid = 0; #1;
    chk("lit_r7_after_wb", inflight, 2);
    chk("lit_r7_fourth_fire", issue_fire, 1);
    tick(); idle(); #1;
    chk("lit_r7_back_to3", inflight, 3);
    for (int i = 0; i < 3; i++) begin wb(7); tick(); end
    idle();

    // Bypass only applies to a count of one
    wr(4); tick(); wr(4); tick();
    idle(); issue_valid = 1; use_rk = 1; issue_rk = 4; wb_valid = 1; wb_rd = 4; #1;
    chk("lit_r4_cnt2_stall", stall, 1);
    tick(); #1;
    chk("lit_r4_cnt1_bypass", stall, 0);
    tick(); idle(); #1;
    chk("lit_r4_drained", inflight, 0);

    // Same-cycle issue and write-back to r9
    wr(9); tick();
    wr(9); wb_valid = 1; wb_rd = 9; #1;
    chk("lit_r9_pair_fire", issue_fire, 1);
    tick(); idle(); #1;
    chk("lit_r9_inflight", inflight, 1);
    chk("lit_r9_busy", busy[9], 1);
    wb(9); tick(); idle();

    // Orphan write-back
    wb(12); tick(); idle(); #1;
    chk("lit_r12_err", wb_err, 1);
    chk("lit_r12_busy", busy[12], 0);

    // Flush with five pending
    foreach (five_regs[k]) begin wr(five_regs[k]); tick(); end
    idle(); #1;
    chk("lit_flush_inflight5", inflight, 5);
    wr(8); flush = 1; #1;
    chk("lit_flush_fire", issue_fire, 0);
    tick(); idle(); #1;
    chk("lit_flush_busy", busy, 0);
    chk("lit_flush_inflight", inflight, 0);
    chk("lit_flush_err_sticky", wb_err, 1);

    // Register zero is never tracked
    idle(); issue_valid = 1; use_rj = 1; use_rk = 1; issue_we = 1; #1;
    chk("lit_r0_stall", stall, 0);
    chk("lit_r0_fire", issue_fire, 1);
    tick(); idle(); wb_valid = 1; #1;
    chk("lit_r0_inflight", inflight, 0);
    tick(); idle();

    // Destination-read hazard, then asynchronous reset mid-sequence
    wr(10); tick();
    wr(3); use_rd = 1; issue_rd = 10; #1;
    chk("lit_rd_stall", stall, 1);
    tick(); idle();
    #2 aresetn = 0;
    #1;
    chk("lit_async_busy", busy, 0);
    chk("lit_async_inflight", inflight, 0);
    chk("lit_async_err", wb_err, 0);
    tick(); tick();
    aresetn = 1;
    wr(11); #1;
    chk("lit_post_rst_fire", issue_fire, 1);
    tick(); idle(); #1;
    chk("lit_post_rst_busy", busy[11], 1);
    wb(11); tick(); idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
